// File: rtl/cg_ctrl_pkg.sv
// Shared types and defaults for the idle clock-gate controller.
// The FSM state enum and the event-counter width live here so the top and the bench agree on them.
package cg_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } cg_state_e;

  localparam int IDLE_CYCLES_DEFAULT = 16;
  localparam int WAKE_CYCLES_DEFAULT = 2;
  localparam int EVENT_W             = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cg_idle_ctrl_if.sv
// Handshake bundle between a gated unit's manager and the idle clock-gate controller.
// Signal names keep the controller-side direction suffixes so both ends read the same.
interface cg_idle_ctrl_if;
  import cg_ctrl_pkg::*;

  logic               busy_i;
  logic               wake_req_i;
  logic               force_on_i;
  logic               enable_o;
  logic               wake_ack_o;
  logic               gated_o;
  logic [EVENT_W-1:0] gate_events_o;

  // Requester side: drives work/wake/override, observes the gate status.
  modport master (
    output busy_i,
    output wake_req_i,
    output force_on_i,
    input  enable_o,
    input  wake_ack_o,
    input  gated_o,
    input  gate_events_o
  );

  // Controller side.
  modport slave (
    input  busy_i,
    input  wake_req_i,
    input  force_on_i,
    output enable_o,
    output wake_ack_o,
    output gated_o,
    output gate_events_o
  );

endinterface

// File: rtl/cg_sat_counter.sv
// Saturating event counter: counts inc_i pulses and sticks at all-ones.
module cg_sat_counter
  import cg_ctrl_pkg::*;
#(
  parameter int Width = EVENT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_reg;
  logic [Width-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (inc_i && (count_reg != {Width{1'b1}})) begin
      count_next = count_reg + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count_o = count_reg;

endmodule

// File: rtl/cg_idle_ctrl.sv
// Idle-driven clock-gate controller: gates after IdleCycles idle cycles, reopens on work/wake,
// and holds the enable high for WakeCycles before declaring the unit running again.
module cg_idle_ctrl
  import cg_ctrl_pkg::*;
#(
  parameter int IdleCycles = IDLE_CYCLES_DEFAULT,
  parameter int WakeCycles = WAKE_CYCLES_DEFAULT
) (
  input logic           clk_i,
  input logic           rst_ni,
  cg_idle_ctrl_if.slave cg
);

  localparam int              CntW     = $clog2(max_int(IdleCycles, WakeCycles) + 1);
  localparam logic [CntW-1:0] IdleLast = CntW'(IdleCycles - 1);
  localparam logic [CntW-1:0] WakeLast = CntW'(WakeCycles - 1);

  cg_state_e          state_reg;
  cg_state_e          state_next;
  logic [CntW-1:0]    cnt_reg;
  logic [CntW-1:0]    cnt_next;
  logic               enable_reg;
  logic               enable_next;
  logic               wake_ack_reg;
  logic               wake_ack_next;
  logic               idle;
  logic               gate_entry;
  logic [EVENT_W-1:0] gate_events;

  // force_on_i folds into idle, so an overridden unit can never reach GATED.
  assign idle = !cg.busy_i && !cg.wake_req_i && !cg.force_on_i;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    gate_entry    = 1'b0;

    unique case (state_reg)
      RUN: begin
        if (idle) begin
          state_next = DRAIN;
          cnt_next   = CntW'(1);
        end else begin
          cnt_next   = '0;
        end
      end
      DRAIN: begin
        if (!idle) begin
          state_next = RUN;
          cnt_next   = '0;
        end else if (cnt_reg == IdleLast) begin
          state_next = GATED;
          gate_entry = 1'b1;
        end else begin
          cnt_next   = cnt_reg + CntW'(1);
        end
      end
      GATED: begin
        if (!idle) begin
          state_next = WAKE;
          cnt_next   = '0;
        end
      end
      WAKE: begin
        // Deliberately ignores idle: once reopened, the clock runs a full wake window.
        if (cnt_reg == WakeLast) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + CntW'(1);
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase

    enable_next   = (state_next != GATED);
    wake_ack_next = (state_reg == RUN) && cg.wake_req_i && !wake_ack_reg;
  end

  // Reset value of enable_reg is 1 so an asserted reset reopens the clock without a low glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= RUN;
      cnt_reg      <= '0;
      enable_reg   <= 1'b1;
      wake_ack_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      enable_reg   <= enable_next;
      wake_ack_reg <= wake_ack_next;
    end
  end

  cg_sat_counter #(
    .Width (EVENT_W)
  ) u_gate_events (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (gate_entry),
    .count_o (gate_events)
  );

  assign cg.enable_o      = enable_reg;
  assign cg.wake_ack_o    = wake_ack_reg;
  assign cg.gated_o       = (state_reg == GATED);
  assign cg.gate_events_o = gate_events;

endmodule
